dbus_packet_ctrl: RTL and testbench
===================================

// Module: dbus_packet_ctrl
// PURPOSE
//  Packet sequencer above the byte-level dbus (TI link) engine. TX: frames host packets (MID, CMD, LEN16, data, CKSUM16) into
//  byte requests. RX: parses received bytes into header, payload and checksum. RX owns the link while a packet is inbound.
//  Lives between the UART/host command logic and the dbus byte engine.
// PARAMETERS
//  TIMEOUT_CYCLES  1_000_000  max i_clock cycles per byte (TX busy wait, RX inter-byte gap) before abort
//  TO_W            20         timeout counter width; must hold TIMEOUT_CYCLES
// PORTS
//  i_clock          in   1   system clock
//  i_reset_n        in   1   asynchronous, active-low reset
//  i_tx_start       in   1   pulse: latch i_tx_mid/cmd/len, start packet (ignored unless o_tx_ready)
//  i_tx_mid         in   8   machine ID byte
//  i_tx_cmd         in   8   command byte
//  i_tx_len         in   16  length field (payload byte count)
//  i_tx_byte        in   8   payload byte
//  i_tx_byte_valid  in   1   payload byte valid
//  o_tx_byte_ready  out  1   payload byte consumed when valid&&ready
//  o_tx_ready       out  1   TX idle, RX idle, link idle
//  o_tx_done        out  1   1-cycle pulse: last byte completed
//  o_rx_hdr_valid   out  1   1-cycle pulse: o_rx_mid/cmd/len valid
//  o_rx_mid         out  8   received machine ID
//  o_rx_cmd         out  8   received command
//  o_rx_len         out  16  received length field
//  o_rx_byte        out  8   received payload byte
//  o_rx_byte_valid  out  1   1-cycle pulse per payload byte
//  o_rx_done        out  1   1-cycle pulse: packet complete
//  o_rx_cksum_ok    out  1   valid with o_rx_done: checksum matched (1 for no-data packets)
//  o_err            out  1   1-cycle pulse: timeout or collision abort
//  o_dbus_data      out  8   byte to engine
//  o_dbus_enable    out  1   byte request to engine
//  o_dbus_read      out  1   1-cycle acknowledge of engine byte
//  i_dbus_data      in   8   engine received byte
//  i_dbus_busy      in   1   engine busy (TX or RX)
//  i_dbus_avail     in   1   engine holds received byte
//  i_dbus_receiving in   1   engine receiving a byte
// BEHAVIOUR
//  - Reset: all outputs 0 except o_tx_ready=1; both FSMs idle; counters 0.
//  - Data section present iff LEN!=0 and CMD in {06,15,36,88,A2,C9}; same rule TX and RX.
//    No data: 4 bytes on wire. Data: 4+LEN+2 bytes.
//  - Byte order: MID, CMD, LEN lo, LEN hi, data[0..LEN-1], CK lo, CK hi.
//    CK = 16-bit sum (mod 2^16) of data bytes only; header not included.
//  - TX FSM: T_IDLE -> T_LOAD -> T_DRIVE -> T_BUSY -> T_LOAD... -> T_IDLE.
//    T_LOAD: select next byte. For payload, wait i_tx_byte_valid; o_tx_byte_ready is 1 only in T_LOAD for payload bytes.
//    Consumed byte is added to the running CK.
//    T_DRIVE: o_dbus_enable=1, o_dbus_data held stable. Leave on i_dbus_busy && !i_dbus_receiving.
//    Enable drops the same cycle.
//    T_BUSY: wait !i_dbus_busy. After the last byte, pulse o_tx_done and go to T_IDLE.
//  - o_tx_ready = T_IDLE && R_IDLE && !i_dbus_busy && !i_dbus_avail && !i_dbus_receiving.
//    If i_tx_start and an RX start coincide, RX wins and the start is dropped.
//  - Collision: i_dbus_receiving or i_dbus_avail during T_DRIVE/T_BUSY -> o_dbus_enable=0, pulse o_err, go to T_IDLE.
//    RX then takes the byte normally as MID.
//  - RX FSM: R_IDLE -> R_HDR(4) -> [R_DATA(LEN)] -> R_CK(2) -> R_IDLE.
//    A byte is taken when i_dbus_avail && !rd_pend: o_dbus_read=1 for one cycle, capture i_dbus_data, set rd_pend.
//    rd_pend clears when i_dbus_avail falls; the engine drops avail up to 2 cycles late, so no double read.
//    R_HDR: o_rx_hdr_valid pulses the cycle after the 4th byte is captured.
//    If there is no data section, o_rx_done and o_rx_cksum_ok=1 pulse with it.
//    R_DATA: o_rx_byte/o_rx_byte_valid per byte, accumulate CK.
//    R_CK: after 2nd CK byte, o_rx_done=1 and o_rx_cksum_ok=(rx CK==calc).
//  - Timeout: counter clears on every state change/byte. At TIMEOUT_CYCLES-1 in any non-idle state: pulse o_err,
//    return that FSM to idle, o_dbus_enable=0. Engine is not reset.
//  - Byte counters 16-bit; LEN=0xFFFF is legal (65535 data bytes); no wrap within a packet.
//  - Async reset mid-packet: FSMs idle immediately, partial packet discarded, no done/err pulse.
// TESTING
//  - TX 09 68 0000: 4 enable/busy cycles, wire bytes 09,68,00,00; o_tx_done once; o_tx_byte_ready never 1.
//  - TX 08 15 len=3 data 01,02,FF: 9 bytes, CK bytes 02,01; stall i_tx_byte_valid 50 cycles mid-payload -> no extra byte.
//  - RX 89 06 len=2 data 10,20 CK 30,00: hdr pulse (89,06,0002); bytes 10,20; o_rx_done with cksum_ok=1.
//    Corrupt CK to 31,00 -> cksum_ok=0.
//  - i_dbus_avail held 3 cycles after o_dbus_read: exactly one read pulse per byte.
//  - TX started, engine asserts i_dbus_receiving in T_DRIVE: o_err pulse, enable low next cycle, RX parses MID.
//  - TIMEOUT_CYCLES=100, RX stops after 2 header bytes: o_err at gap cycle 100, RX idle, o_tx_ready=1.

Source files
------------

// File: rtl/dbus_packet_ctrl.sv
// -----------------------------------------------------------------------------
// dbus_packet_ctrl
//   Packet sequencer that sits between the host command logic and the
//   byte-level dbus (TI link) engine.
//
//   Wire format: MID, CMD, LEN lo, LEN hi, [data[0..LEN-1], CK lo, CK hi].
//   The data section and checksum exist only when LEN != 0 and CMD is one of
//   06, 15, 36, 88, A2, C9. CK is the 16-bit sum of the data bytes only.
//
//   TX side: frames a host packet into byte requests to the engine.
//   RX side: parses engine bytes into header, payload and checksum. RX owns
//   the link while a packet is inbound (TX cannot start unless RX is idle).
//
// Ports
//   i_clock, i_reset_n          clock, asynchronous active-low reset
//   i_tx_start/mid/cmd/len      packet start pulse and header fields
//   i_tx_byte/_valid,
//   o_tx_byte_ready             payload stream (consumed on valid && ready)
//   o_tx_ready                  TX, RX and link all idle
//   o_tx_done                   pulse: last TX byte completed
//   o_rx_hdr_valid/mid/cmd/len  received header, pulse-qualified
//   o_rx_byte/_valid            received payload byte, one pulse per byte
//   o_rx_done, o_rx_cksum_ok    packet complete, checksum verdict
//   o_err                       pulse: timeout or collision abort
//   o_dbus_data/enable          byte request to the engine
//   o_dbus_read                 one-cycle acknowledge of an engine byte
//   i_dbus_data/busy/avail/
//   i_dbus_receiving            engine status and received byte
//   o_dbg_tx_state/rx_state     FSM state for debug/checkers
//
// Handshake: the host payload stream is valid/ready; a byte transfers on a
// cycle where i_tx_byte_valid && o_tx_byte_ready, and valid must be held
// with stable data until that cycle. Ready never depends on valid.
// -----------------------------------------------------------------------------
module dbus_packet_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_W           = 20
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_tx_start,
  input  logic [7:0]  i_tx_mid,
  input  logic [7:0]  i_tx_cmd,
  input  logic [15:0] i_tx_len,
  input  logic [7:0]  i_tx_byte,
  input  logic        i_tx_byte_valid,
  output logic        o_tx_byte_ready,
  output logic        o_tx_ready,
  output logic        o_tx_done,
  output logic        o_rx_hdr_valid,
  output logic [7:0]  o_rx_mid,
  output logic [7:0]  o_rx_cmd,
  output logic [15:0] o_rx_len,
  output logic [7:0]  o_rx_byte,
  output logic        o_rx_byte_valid,
  output logic        o_rx_done,
  output logic        o_rx_cksum_ok,
  output logic        o_err,
  output logic [7:0]  o_dbus_data,
  output logic        o_dbus_enable,
  output logic        o_dbus_read,
  input  logic [7:0]  i_dbus_data,
  input  logic        i_dbus_busy,
  input  logic        i_dbus_avail,
  input  logic        i_dbus_receiving,
  output logic [1:0]  o_dbg_tx_state,
  output logic [1:0]  o_dbg_rx_state
);

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] T_DRIVE = 2'd2;
  localparam logic [1:0] T_BUSY  = 2'd3;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_HDR   = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_CK    = 2'd3;

  // TX packet section; the byte counter restarts in each section so that a
  // 65535-byte payload never needs a counter wider than 16 bits.
  localparam logic [1:0] SEC_HDR  = 2'd0;
  localparam logic [1:0] SEC_DATA = 2'd1;
  localparam logic [1:0] SEC_CK   = 2'd2;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic has_data(input logic [7:0] cmd, input logic [15:0] len);
    logic cmd_hit;
    cmd_hit = (cmd == 8'h06) || (cmd == 8'h15) || (cmd == 8'h36) ||
              (cmd == 8'h88) || (cmd == 8'hA2) || (cmd == 8'hC9);
    return cmd_hit && (len != 16'd0);
  endfunction

  // ---------------------------------------------------------------- TX state
  logic [1:0]      tx_state_q, tx_state_d;
  logic [1:0]      tx_sec_q,   tx_sec_d;
  logic [15:0]     tx_cnt_q,   tx_cnt_d;
  logic [7:0]      tx_mid_q,   tx_mid_d;
  logic [7:0]      tx_cmd_q,   tx_cmd_d;
  logic [15:0]     tx_len_q,   tx_len_d;
  logic [7:0]      tx_data_q,  tx_data_d;
  logic [15:0]     tx_ck_q,    tx_ck_d;
  logic [TO_W-1:0] tx_to_q,    tx_to_d;
  logic            tx_done_q,  tx_done_d;

  // ---------------------------------------------------------------- RX state
  logic [1:0]      rx_state_q, rx_state_d;
  logic [15:0]     rx_cnt_q,   rx_cnt_d;
  logic [7:0]      rx_mid_q,   rx_mid_d;
  logic [7:0]      rx_cmd_q,   rx_cmd_d;
  logic [15:0]     rx_len_q,   rx_len_d;
  logic [7:0]      rx_byte_q,  rx_byte_d;
  logic [15:0]     rx_ck_q,    rx_ck_d;
  logic [7:0]      rx_cklo_q,  rx_cklo_d;
  logic [TO_W-1:0] rx_to_q,    rx_to_d;
  logic            rd_pend_q,  rd_pend_d;
  logic            rd_ack_q,   rd_ack_d;
  logic            hdr_vld_q,  hdr_vld_d;
  logic            byte_vld_q, byte_vld_d;
  logic            rx_done_q,  rx_done_d;
  logic            ck_ok_q,    ck_ok_d;
  logic            err_q,      err_d;

  logic tx_ready;
  logic tx_abort;
  logic tx_byte_ready;
  logic dbus_enable;
  logic collide;
  logic tx_to_hit;
  logic rx_abort;
  logic rx_take;
  logic rx_to_hit;

  assign tx_ready = (tx_state_q == T_IDLE) && (rx_state_q == R_IDLE) &&
                    !i_dbus_busy && !i_dbus_avail && !i_dbus_receiving;
  // Any inbound activity while we own the wire means the other end talked
  // over us; RX picks that byte up as a new MID.
  assign collide   = i_dbus_receiving || i_dbus_avail;
  assign tx_to_hit = (tx_state_q != T_IDLE) && (tx_to_q == TO_LAST);

  // ---------------------------------------------------------------- TX FSM
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_sec_d      = tx_sec_q;
    tx_cnt_d      = tx_cnt_q;
    tx_mid_d      = tx_mid_q;
    tx_cmd_d      = tx_cmd_q;
    tx_len_d      = tx_len_q;
    tx_data_d     = tx_data_q;
    tx_ck_d       = tx_ck_q;
    tx_done_d     = 1'b0;
    tx_abort      = 1'b0;
    tx_byte_ready = 1'b0;
    dbus_enable   = 1'b0;

    case (tx_state_q)
      T_IDLE: begin
        // tx_ready already excludes an RX start (avail high), so a start that
        // coincides with inbound traffic is simply dropped.
        if (i_tx_start && tx_ready) begin
          tx_mid_d   = i_tx_mid;
          tx_cmd_d   = i_tx_cmd;
          tx_len_d   = i_tx_len;
          tx_sec_d   = SEC_HDR;
          tx_cnt_d   = 16'd0;
          tx_ck_d    = 16'd0;
          tx_state_d = T_LOAD;
        end
      end

      T_LOAD: begin
        case (tx_sec_q)
          SEC_HDR: begin
            case (tx_cnt_q[1:0])
              2'd0:    tx_data_d = tx_mid_q;
              2'd1:    tx_data_d = tx_cmd_q;
              2'd2:    tx_data_d = tx_len_q[7:0];
              default: tx_data_d = tx_len_q[15:8];
            endcase
            tx_state_d = T_DRIVE;
          end
          SEC_DATA: begin
            tx_byte_ready = 1'b1;
            if (i_tx_byte_valid) begin
              tx_data_d  = i_tx_byte;
              tx_ck_d    = tx_ck_q + {8'd0, i_tx_byte};
              tx_state_d = T_DRIVE;
            end
          end
          default: begin
            tx_data_d  = tx_cnt_q[0] ? tx_ck_q[15:8] : tx_ck_q[7:0];
            tx_state_d = T_DRIVE;
          end
        endcase
      end

      T_DRIVE: begin
        // Request drops combinationally as soon as the engine reports busy.
        dbus_enable = !i_dbus_busy && !collide;
        if (collide) begin
          tx_abort   = 1'b1;
          tx_state_d = T_IDLE;
        end else if (i_dbus_busy) begin
          tx_state_d = T_BUSY;
        end
      end

      T_BUSY: begin
        if (collide) begin
          tx_abort   = 1'b1;
          tx_state_d = T_IDLE;
        end else if (!i_dbus_busy) begin
          tx_state_d = T_LOAD;
          case (tx_sec_q)
            SEC_HDR: begin
              if (tx_cnt_q == 16'd3) begin
                if (has_data(tx_cmd_q, tx_len_q)) begin
                  tx_sec_d = SEC_DATA;
                  tx_cnt_d = 16'd0;
                end else begin
                  tx_done_d  = 1'b1;
                  tx_state_d = T_IDLE;
                end
              end else begin
                tx_cnt_d = tx_cnt_q + 16'd1;
              end
            end
            SEC_DATA: begin
              if (tx_cnt_q == tx_len_q - 16'd1) begin
                tx_sec_d = SEC_CK;
                tx_cnt_d = 16'd0;
              end else begin
                tx_cnt_d = tx_cnt_q + 16'd1;
              end
            end
            default: begin
              if (tx_cnt_q[0]) begin
                tx_done_d  = 1'b1;
                tx_state_d = T_IDLE;
              end else begin
                tx_cnt_d = 16'd1;
              end
            end
          endcase
        end
      end

      default: tx_state_d = T_IDLE;
    endcase

    // Timeout overrides everything: no byte is consumed or requested.
    if (tx_to_hit) begin
      tx_state_d    = T_IDLE;
      tx_abort      = 1'b1;
      tx_done_d     = 1'b0;
      tx_byte_ready = 1'b0;
      dbus_enable   = 1'b0;
    end

    if ((tx_state_q == T_IDLE) || (tx_state_d != tx_state_q)) begin
      tx_to_d = '0;
    end else begin
      tx_to_d = tx_to_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------- RX FSM
  // The engine may keep avail high for a couple of cycles after our read
  // pulse; rd_pend blocks a second capture until avail has fallen.
  assign rx_take   = i_dbus_avail && !rd_pend_q;
  assign rx_to_hit = (rx_state_q != R_IDLE) && (rx_to_q == TO_LAST) && !rx_take;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_mid_d   = rx_mid_q;
    rx_cmd_d   = rx_cmd_q;
    rx_len_d   = rx_len_q;
    rx_byte_d  = rx_byte_q;
    rx_ck_d    = rx_ck_q;
    rx_cklo_d  = rx_cklo_q;
    hdr_vld_d  = 1'b0;
    byte_vld_d = 1'b0;
    rx_done_d  = 1'b0;
    ck_ok_d    = 1'b0;
    rx_abort   = 1'b0;
    rd_ack_d   = rx_take;

    if (rx_take) begin
      rd_pend_d = 1'b1;
    end else if (!i_dbus_avail) begin
      rd_pend_d = 1'b0;
    end else begin
      rd_pend_d = rd_pend_q;
    end

    case (rx_state_q)
      R_IDLE: begin
        if (rx_take) begin
          rx_mid_d   = i_dbus_data;
          rx_cnt_d   = 16'd1;
          rx_state_d = R_HDR;
        end
      end

      R_HDR: begin
        if (rx_take) begin
          case (rx_cnt_q[1:0])
            2'd1: begin
              rx_cmd_d = i_dbus_data;
              rx_cnt_d = 16'd2;
            end
            2'd2: begin
              rx_len_d[7:0] = i_dbus_data;
              rx_cnt_d      = 16'd3;
            end
            default: begin
              rx_len_d[15:8] = i_dbus_data;
              hdr_vld_d      = 1'b1;
              rx_cnt_d       = 16'd0;
              if (has_data(rx_cmd_q, {i_dbus_data, rx_len_q[7:0]})) begin
                rx_ck_d    = 16'd0;
                rx_state_d = R_DATA;
              end else begin
                // Header-only packet completes with the header pulse.
                rx_done_d  = 1'b1;
                ck_ok_d    = 1'b1;
                rx_state_d = R_IDLE;
              end
            end
          endcase
        end
      end

      R_DATA: begin
        if (rx_take) begin
          rx_byte_d  = i_dbus_data;
          byte_vld_d = 1'b1;
          rx_ck_d    = rx_ck_q + {8'd0, i_dbus_data};
          if (rx_cnt_q == rx_len_q - 16'd1) begin
            rx_cnt_d   = 16'd0;
            rx_state_d = R_CK;
          end else begin
            rx_cnt_d = rx_cnt_q + 16'd1;
          end
        end
      end

      R_CK: begin
        if (rx_take) begin
          if (rx_cnt_q == 16'd0) begin
            rx_cklo_d = i_dbus_data;
            rx_cnt_d  = 16'd1;
          end else begin
            rx_done_d  = 1'b1;
            ck_ok_d    = ({i_dbus_data, rx_cklo_q} == rx_ck_q);
            rx_cnt_d   = 16'd0;
            rx_state_d = R_IDLE;
          end
        end
      end

      default: rx_state_d = R_IDLE;
    endcase

    if (rx_to_hit) begin
      rx_state_d = R_IDLE;
      rx_cnt_d   = 16'd0;
      rx_abort   = 1'b1;
    end

    // State only changes on a captured byte or a timeout, so clearing on
    // either covers "clear on every state change or byte".
    if (rx_take || rx_to_hit || (rx_state_q == R_IDLE)) begin
      rx_to_d = '0;
    end else begin
      rx_to_d = rx_to_q + 1'b1;
    end

    err_d = tx_abort || rx_abort;
  end

  // ---------------------------------------------------------------- flops
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_state_q <= T_IDLE;
      tx_sec_q   <= SEC_HDR;
      tx_cnt_q   <= 16'd0;
      tx_mid_q   <= 8'd0;
      tx_cmd_q   <= 8'd0;
      tx_len_q   <= 16'd0;
      tx_data_q  <= 8'd0;
      tx_ck_q    <= 16'd0;
      tx_to_q    <= '0;
      tx_done_q  <= 1'b0;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_mid_q   <= 8'd0;
      rx_cmd_q   <= 8'd0;
      rx_len_q   <= 16'd0;
      rx_byte_q  <= 8'd0;
      rx_ck_q    <= 16'd0;
      rx_cklo_q  <= 8'd0;
      rx_to_q    <= '0;
      rd_pend_q  <= 1'b0;
      rd_ack_q   <= 1'b0;
      hdr_vld_q  <= 1'b0;
      byte_vld_q <= 1'b0;
      rx_done_q  <= 1'b0;
      ck_ok_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_sec_q   <= tx_sec_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_mid_q   <= tx_mid_d;
      tx_cmd_q   <= tx_cmd_d;
      tx_len_q   <= tx_len_d;
      tx_data_q  <= tx_data_d;
      tx_ck_q    <= tx_ck_d;
      tx_to_q    <= tx_to_d;
      tx_done_q  <= tx_done_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_mid_q   <= rx_mid_d;
      rx_cmd_q   <= rx_cmd_d;
      rx_len_q   <= rx_len_d;
      rx_byte_q  <= rx_byte_d;
      rx_ck_q    <= rx_ck_d;
      rx_cklo_q  <= rx_cklo_d;
      rx_to_q    <= rx_to_d;
      rd_pend_q  <= rd_pend_d;
      rd_ack_q   <= rd_ack_d;
      hdr_vld_q  <= hdr_vld_d;
      byte_vld_q <= byte_vld_d;
      rx_done_q  <= rx_done_d;
      ck_ok_q    <= ck_ok_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign o_tx_byte_ready = tx_byte_ready;
  assign o_tx_ready      = tx_ready;
  assign o_tx_done       = tx_done_q;
  assign o_rx_hdr_valid  = hdr_vld_q;
  assign o_rx_mid        = rx_mid_q;
  assign o_rx_cmd        = rx_cmd_q;
  assign o_rx_len        = rx_len_q;
  assign o_rx_byte       = rx_byte_q;
  assign o_rx_byte_valid = byte_vld_q;
  assign o_rx_done       = rx_done_q;
  assign o_rx_cksum_ok   = ck_ok_q;
  assign o_err           = err_q;
  assign o_dbus_data     = tx_data_q;
  assign o_dbus_enable   = dbus_enable;
  assign o_dbus_read     = rd_ack_q;
  assign o_dbg_tx_state  = tx_state_q;
  assign o_dbg_rx_state  = rx_state_q;

endmodule

// File: tb/tb_dbus_packet_ctrl.sv
`timescale 1ns/1ps
module tb_dbus_packet_ctrl;

  localparam int TO = 100;

  // ---------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        i_tx_start, i_tx_byte_valid;
  logic [7:0]  i_tx_mid, i_tx_cmd, i_tx_byte, i_dbus_data;
  logic [15:0] i_tx_len;
  logic        i_dbus_avail, i_dbus_receiving;
  logic        eng_busy;
  logic        o_tx_byte_ready, o_tx_ready, o_tx_done, o_rx_hdr_valid;
  logic [7:0]  o_rx_mid, o_rx_cmd, o_rx_byte, o_dbus_data;
  logic [15:0] o_rx_len;
  logic        o_rx_byte_valid, o_rx_done, o_rx_cksum_ok, o_err;
  logic        o_dbus_enable, o_dbus_read;
  logic [1:0]  o_dbg_tx_state, o_dbg_rx_state;

  dbus_packet_ctrl #(.TIMEOUT_CYCLES(TO), .TO_W(7)) dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_tx_start(i_tx_start), .i_tx_mid(i_tx_mid), .i_tx_cmd(i_tx_cmd), .i_tx_len(i_tx_len),
    .i_tx_byte(i_tx_byte), .i_tx_byte_valid(i_tx_byte_valid), .o_tx_byte_ready(o_tx_byte_ready),
    .o_tx_ready(o_tx_ready), .o_tx_done(o_tx_done),
    .o_rx_hdr_valid(o_rx_hdr_valid), .o_rx_mid(o_rx_mid), .o_rx_cmd(o_rx_cmd), .o_rx_len(o_rx_len),
    .o_rx_byte(o_rx_byte), .o_rx_byte_valid(o_rx_byte_valid), .o_rx_done(o_rx_done),
    .o_rx_cksum_ok(o_rx_cksum_ok), .o_err(o_err),
    .o_dbus_data(o_dbus_data), .o_dbus_enable(o_dbus_enable), .o_dbus_read(o_dbus_read),
    .i_dbus_data(i_dbus_data), .i_dbus_busy(eng_busy), .i_dbus_avail(i_dbus_avail),
    .i_dbus_receiving(i_dbus_receiving),
    .o_dbg_tx_state(o_dbg_tx_state), .o_dbg_rx_state(o_dbg_rx_state)
  );

  // ---------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_wire_q[$];
  logic [7:0]  wire_obs_q[$];
  logic [31:0] exp_hdr_q[$];
  logic [7:0]  exp_rxb_q[$];
  logic [0:0]  exp_done_q[$];
  logic [7:0]  pay_q[$];
  logic [7:0]  rx_q[$];
  int tx_done_cnt = 0, err_cnt = 0, read_cnt = 0, bready_cnt = 0;
  int hdr_cnt = 0, rxdone_cnt = 0, cyc = 0, last_read_cyc = 0, last_err_cyc = 0;
  logic last_ok = 1'b0;
  bit eng_accept = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation pending", name);
  endtask

  // ---------------------------------------------------------- model
  function automatic logic model_has_data(input logic [7:0] cmd, input logic [15:0] len);
    return (len != 16'd0) && (cmd inside {8'h06, 8'h15, 8'h36, 8'h88, 8'hA2, 8'hC9});
  endfunction

  function automatic logic [15:0] model_sum();
    int s = 0;
    foreach (pay_q[i]) s += int'(pay_q[i]);
    return 16'(s % 65536);
  endfunction

  // Expected wire bytes for a host packet whose payload is pay_q.
  task automatic model_tx(input logic [7:0] mid, input logic [7:0] cmd, input logic [15:0] len);
    logic [15:0] ck;
    exp_wire_q.push_back(mid);
    exp_wire_q.push_back(cmd);
    exp_wire_q.push_back(len[7:0]);
    exp_wire_q.push_back(len[15:8]);
    if (model_has_data(cmd, len)) begin
      foreach (pay_q[i]) exp_wire_q.push_back(pay_q[i]);
      ck = model_sum();
      exp_wire_q.push_back(ck[7:0]);
      exp_wire_q.push_back(ck[15:8]);
    end
  endtask

  // Builds rx_q for an inbound packet (payload pay_q, checksum ck_wire on the
  // wire) and the events the parser must report for it.
  task automatic model_rx(input logic [7:0] mid, input logic [7:0] cmd, input logic [15:0] len,
                          input logic [15:0] ck_wire);
    rx_q = {mid, cmd, len[7:0], len[15:8]};
    exp_hdr_q.push_back({mid, cmd, len});
    if (model_has_data(cmd, len)) begin
      foreach (pay_q[i]) begin
        rx_q.push_back(pay_q[i]);
        exp_rxb_q.push_back(pay_q[i]);
      end
      rx_q.push_back(ck_wire[7:0]);
      rx_q.push_back(ck_wire[15:8]);
      exp_done_q.push_back(ck_wire == model_sum());
    end else begin
      exp_done_q.push_back(1'b1);
    end
  endtask

  // ---------------------------------------------------------- compare process
  always @(negedge clk) begin
    cyc++;
    if (o_dbus_enable && eng_accept) begin
      wire_obs_q.push_back(o_dbus_data);
      if (exp_wire_q.size() == 0) unexpected("wire_byte");
      else chk("wire_byte", o_dbus_data, exp_wire_q.pop_front());
    end
    if (o_tx_done) begin
      tx_done_cnt++;
      chk("tx_done_after_last_byte", exp_wire_q.size(), 0);
    end
    if (o_rx_hdr_valid) begin
      hdr_cnt++;
      if (exp_hdr_q.size() == 0) unexpected("rx_hdr");
      else chk("rx_hdr", {o_rx_mid, o_rx_cmd, o_rx_len}, exp_hdr_q.pop_front());
    end
    if (o_rx_byte_valid) begin
      if (exp_rxb_q.size() == 0) unexpected("rx_byte");
      else chk("rx_byte", o_rx_byte, exp_rxb_q.pop_front());
    end
    if (o_rx_done) begin
      rxdone_cnt++;
      last_ok = o_rx_cksum_ok;
      if (exp_done_q.size() == 0) unexpected("rx_done");
      else chk("rx_cksum_ok", o_rx_cksum_ok, exp_done_q.pop_front());
    end
    if (o_dbus_read) begin
      read_cnt++;
      last_read_cyc = cyc;
    end
    if (o_err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (o_tx_byte_ready) bready_cnt++;
  end

  // ---------------------------------------------------------- engine (TX side)
  // Sees a request, waits one cycle, goes busy for three cycles.
  initial begin
    eng_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (o_dbus_enable && eng_accept && !eng_busy) begin
        @(posedge clk);
        #1 eng_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 eng_busy = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------- driver tasks
  task automatic tx_send(input logic [7:0] mid, input logic [7:0] cmd, input logic [15:0] len,
                         input int stall_at);
    int d0, t, n;
    d0 = tx_done_cnt;
    wire_obs_q.delete();
    model_tx(mid, cmd, len);
    n = model_has_data(cmd, len) ? int'(len) : 0;
    chk("tx_ready_before_start", o_tx_ready, 1);
    i_tx_mid = mid; i_tx_cmd = cmd; i_tx_len = len; i_tx_start = 1'b1;
    @(negedge clk);
    i_tx_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        i_tx_byte_valid = 1'b0;
        repeat (50) @(negedge clk);
      end
      i_tx_byte = pay_q[i];
      i_tx_byte_valid = 1'b1;
      t = 0;
      while (!o_tx_byte_ready && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) unexpected("tx_byte_ready_wait");
      @(posedge clk);
      #1 i_tx_byte_valid = 1'b0;
      @(negedge clk);
    end
    t = 0;
    while (tx_done_cnt == d0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk("tx_done_pulses", tx_done_cnt - d0, 1);
  endtask

  task automatic rx_send(input int hold);
    int t;
    foreach (rx_q[i]) begin
      i_dbus_data = rx_q[i];
      i_dbus_receiving = 1'b1;
      @(negedge clk);
      i_dbus_receiving = 1'b0;
      i_dbus_avail = 1'b1;
      t = 0;
      while (!o_dbus_read && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) unexpected("rx_read_wait");
      repeat (hold) @(negedge clk);
      i_dbus_avail = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------------------------------------------------- watchdog
  initial begin
    #2ms;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------------------------------------------------- main sequence
  initial begin
    int r0, d0, e0, h0, t, b0;
    i_tx_start = 0; i_tx_mid = 0; i_tx_cmd = 0; i_tx_len = 0;
    i_tx_byte = 0; i_tx_byte_valid = 0;
    i_dbus_data = 0; i_dbus_avail = 0; i_dbus_receiving = 0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", o_tx_ready, 1);
    chk("rst_pulses", {o_tx_done, o_rx_hdr_valid, o_rx_byte_valid, o_rx_done, o_rx_cksum_ok, o_err}, 0);
    chk("rst_dbus", {o_dbus_enable, o_dbus_read, o_dbus_data}, 0);
    chk("rst_rx_fields", {o_rx_mid, o_rx_cmd, o_rx_len}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_states", {o_dbg_tx_state, o_dbg_rx_state}, 0);

    // Header-only TX: CMD 68 is not a data command.
    b0 = bready_cnt;
    pay_q.delete();
    tx_send(8'h09, 8'h68, 16'h0000, -1);
    chk("tx_nodata_bytes", wire_obs_q.size(), 4);
    chk("tx_nodata_wire", {wire_obs_q[0], wire_obs_q[1], wire_obs_q[2], wire_obs_q[3]}, 32'h0968_0000);
    chk("tx_nodata_no_ready", bready_cnt - b0, 0);

    // Data TX with a 50-cycle host stall before the second payload byte.
    pay_q = {8'h01, 8'h02, 8'hFF};
    chk("model_ck_tx", model_sum(), 16'h0102);
    tx_send(8'h08, 8'h15, 16'h0003, 1);
    chk("tx_data_bytes", wire_obs_q.size(), 9);
    chk("tx_data_ck", {wire_obs_q[7], wire_obs_q[8]}, 16'h0201);

    // RX with data, avail held 3 cycles after each read.
    pay_q = {8'h10, 8'h20};
    chk("model_ck_rx", model_sum(), 16'h0030);
    r0 = read_cnt; d0 = rxdone_cnt;
    model_rx(8'h89, 8'h06, 16'h0002, 16'h0030);
    rx_send(3);
    chk("rx_one_read_per_byte", read_cnt - r0, 8);
    chk("rx_done_once", rxdone_cnt - d0, 1);
    chk("rx_ok_literal", last_ok, 1);

    // Corrupted checksum.
    model_rx(8'h89, 8'h06, 16'h0002, 16'h0031);
    rx_send(1);
    chk("rx_bad_ck_literal", last_ok, 0);

    // Non-data command with a nonzero length: header only, ok=1.
    pay_q.delete();
    model_rx(8'h12, 8'h34, 16'h0005, 16'h0000);
    rx_send(2);
    // Data command with LEN=0: also header only.
    model_rx(8'h01, 8'hC9, 16'h0000, 16'h0000);
    rx_send(0);

    // Collision: engine reports receiving while the request is up.
    eng_accept = 1'b0;
    e0 = err_cnt;
    i_tx_mid = 8'h09; i_tx_cmd = 8'h68; i_tx_len = 16'h0000; i_tx_start = 1'b1;
    @(negedge clk);
    i_tx_start = 1'b0;
    t = 0;
    while (!o_dbus_enable && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("coll_enable_seen", o_dbus_enable, 1);
    i_dbus_receiving = 1'b1;
    @(negedge clk);
    chk("coll_err", o_err, 1);
    chk("coll_enable_low", o_dbus_enable, 0);
    chk("coll_tx_idle", o_dbg_tx_state, 0);
    eng_accept = 1'b1;
    model_rx(8'h55, 8'h09, 16'h0000, 16'h0000);
    rx_send(1);
    chk("coll_err_once", err_cnt - e0, 1);

    // Inter-byte timeout after two header bytes.
    e0 = err_cnt; h0 = hdr_cnt;
    rx_q = {8'h89, 8'h06};
    rx_send(1);
    t = 0;
    while (err_cnt == e0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("to_err_once", err_cnt - e0, 1);
    chk("to_gap_cycles", last_err_cyc - last_read_cyc, TO);
    chk("to_rx_idle", o_dbg_rx_state, 0);
    chk("to_tx_ready", o_tx_ready, 1);
    chk("to_no_hdr", hdr_cnt - h0, 0);

    // Async reset mid-packet: no done/err, then a clean packet parses.
    e0 = err_cnt; h0 = hdr_cnt; d0 = rxdone_cnt;
    rx_q = {8'hAA, 8'h06, 8'h02};
    rx_send(1);
    rst_n = 1'b0;
    #1;
    chk("arst_rx_idle", o_dbg_rx_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_no_pulses", {err_cnt - e0, hdr_cnt - h0, rxdone_cnt - d0}, 0);
    model_rx(8'h77, 8'h36, 16'h0000, 16'h0000);
    rx_send(1);

    chk("left_wire", exp_wire_q.size(), 0);
    chk("left_hdr", exp_hdr_q.size(), 0);
    chk("left_rxb", exp_rxb_q.size(), 0);
    chk("left_done", exp_done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
